// File: rtl/add_serial_arb.sv
// Round-robin sequencer that shares one bit-serial 8-bit adder among NREQ requesters.
// Each operation runs launch, wait, capture, release and gap on the adder, then returns the sum.
module add_serial_arb #(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              busy,
    output logic              add_en,
    output logic [7:0]        add_a,
    output logic [7:0]        add_b,
    input  logic [7:0]        add_out
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_RELEASE = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_nxt;
    logic            w_any;

    // First requester at or after p, wrapping at NREQ; returns p when none is requesting.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
        logic [2*NREQ-1:0] dbl;
        logic [IW-1:0]     pick;
        logic              found;
        int                j;
        dbl   = {r, r} >> p;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(p) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && dbl[k]) begin
                pick  = IW'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        return NREQ'(1) << i;
    endfunction

    // Arbitration decision for the current IDLE cycle and the pointer that follows it.
    always_comb begin
        w_any = |req;
        w_win = rr_pick(req, r_ptr);
        if (w_win == IW'(NREQ - 1)) begin
            w_nxt = '0;
        end else begin
            w_nxt = w_win + IW'(1);
        end
    end

    // Sequencer FSM; every output is registered and set on the transition into its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= 8'h00;
            busy      <= 1'b0;
            add_en    <= 1'b0;
            add_a     <= 8'h00;
            add_b     <= 8'h00;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            add_en    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_idx   <= w_win;
                        r_ptr   <= w_nxt;
                        add_a   <= req_a[8*w_win +: 8];
                        add_b   <= req_b[8*w_win +: 8];
                        gnt     <= onehot(w_win);
                        add_en  <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= S_LAUNCH;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= CW'(ADD_LAT - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_cnt   <= r_cnt - CW'(1);
                    end
                end
                S_CAPTURE: begin
                    rsp_data <= add_out;
                    // Second enable pulse returns the adder from done to idle.
                    add_en   <= 1'b1;
                    r_state  <= S_RELEASE;
                end
                S_RELEASE: begin
                    rsp_valid <= onehot(r_idx);
                    r_state   <= S_GAP;
                end
                S_GAP: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/add_serial_arb.md
# add_serial_arb

Round-robin arbiter and sequencer that shares one 8-bit bit-serial adder among `NREQ` requesters. It accepts operand pairs over a per-requester req/gnt handshake and drives the adder's enable/operand inputs through a full launch, wait, capture and release cycle. It returns the 8-bit sum to the winning requester with a one-cycle valid pulse. It sits between the requesting datapath blocks and a single adder instance; the adder is reset by the same `rst`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `ADD_LAT`, 10: cycles from the adder accepting `add_en` until `add_out` is final (≥1).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request level.
- `req_a`  in  8*NREQ  operand A; requester i uses bits [8i+7:8i].
- `req_b`  in  8*NREQ  operand B, same packing.
- `gnt`  out  NREQ  one-hot, one-cycle pulse: operands of requester i captured.
- `rsp_valid`  out  NREQ  one-hot, one-cycle pulse: `rsp_data` valid for requester i.
- `rsp_data`  out  8  sum (a+b) mod 256; holds until the next capture.
- `busy`  out  1  high in every state except IDLE.
- `add_en`  out  1  adder enable, active-high at this port.
- `add_a`  out  8  adder operand A.
- `add_b`  out  8  adder operand B.
- `add_out`  in  8  adder result.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, CAPTURE, RELEASE, GAP.
- IDLE:
  - If any `req` bit is high, select winner i by round-robin from pointer `ptr`, scanning ptr, ptr+1, … with wrap at NREQ.
  - Latch `req_a`/`req_b` slice i into `add_a`/`add_b` and store i.
  - Set `ptr` to (i+1) mod NREQ and go to LAUNCH.
- LAUNCH:
  - `add_en`=1 and `gnt[i]`=1 for this one cycle.
  - Load the wait counter with ADD_LAT-1 and go to WAIT.
- WAIT: decrement the counter each cycle; at 0 go to CAPTURE.
- CAPTURE: `rsp_data` <= `add_out`; go to RELEASE.
- RELEASE: `add_en`=1 for one cycle, which returns the adder from its done state to idle; go to GAP.
- GAP:
  - `add_en`=0, the mandatory idle cycle so the adder does not relaunch.
  - `rsp_valid[i]`=1; go to IDLE.
- `add_en` is 0 in IDLE, WAIT, CAPTURE and GAP. `add_a`/`add_b` stay stable from LAUNCH through GAP.
- Requester rules:
  - Hold `req` and operands stable until `gnt` is seen, then drop `req`.
  - A `req` still high in IDLE after `rsp_valid` counts as a new request.
  - A `req` dropped before grant is never granted; no lockup results.
- Requests arriving while `busy` wait; there is no queueing beyond the level `req` inputs.
- Arithmetic: 8-bit result, carry-out discarded (0xFF+0x01 = 0x00).

## Timing
- Reset values: `gnt`=0, `rsp_valid`=0, `rsp_data`=0x00, `busy`=0, `add_en`=0, `add_a`=`add_b`=0x00, `ptr`=0, state IDLE.
- Reset mid-operation:
  - All of the above apply on the next edge and any in-flight request is abandoned; no `rsp_valid` is issued.
  - The adder resets on the same edge.
- Latency, edges relative to the edge E0 that samples `req` in IDLE:
  - LAUNCH is cycle E0+1 (`gnt` visible).
  - CAPTURE is at E0+ADD_LAT+2.
  - `rsp_valid` is visible in the cycle after E0+ADD_LAT+3, i.e. ADD_LAT+4 cycles after E0.
  - Default: 14 cycles.
- Throughput: one operation every ADD_LAT+5 cycles under continuous request, IDLE included. Default: 15 cycles.
- Simultaneous requests: exactly one `gnt` bit per operation, never two.
- `ptr` wraps NREQ-1 → 0.

## Test plan
- Single request: reset, then req[0]=1, a=0x12, b=0x34 → `gnt`=0001 at E0+1, `add_en` pulses at E0+1 and E0+ADD_LAT+3, `rsp_valid`=0001 with `rsp_data`=0x46 at E0+14; `busy` low after.
- Overflow: req[2], a=0xFF, b=0x01 → `rsp_data`=0x00, `rsp_valid`=0100; a=0x80, b=0x80 → 0x00.
- Round-robin: all four `req` held high, each dropped after its `gnt` and re-raised after its `rsp_valid` → grant order 0,1,2,3,0; consecutive `gnt` pulses 15 cycles apart.
- Pointer fairness: req[3] served, then req[0] and req[3] raised together → req[0] granted first (ptr wrapped to 0), then req[3].
- Reset mid-WAIT: assert `rst` 5 cycles after `gnt` → next cycle all outputs at reset values, no `rsp_valid`; a fresh request afterwards completes correctly.
- Withdrawn request: req[1] pulsed for one cycle while `busy` → no `gnt[1]` ever; FSM returns to IDLE, `busy`=0.
